vdp_reg_writer: RTL and testbench



---
 rtl/vdp_reg_writer.sv | 154 +++++++++++++++
 tb/tb_vdp_reg_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_reg_writer.sv
// rtl/vdp_reg_writer.sv - command FIFO and strobe sequencer driving the VDP CPU port
module vdp_reg_writer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_vram,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic [1:0] vdp_mode,
  output logic       vdp_write,
  output logic       vdp_read,
  output logic [7:0] vdp_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;
  typedef enum logic [1:0] {PH_SEL = 2'd0, PH_DAT = 2'd1, PH_VRM = 2'd2} phase_t;

  logic [16:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          empty, push, pop;
  logic [16:0]   head;
  logic          head_vram, head_hit;
  logic [7:0]    head_addr, head_data;

  state_t        state, state_d;
  phase_t        phase, phase_d;
  logic [CW-1:0] cnt;
  logic          dat_pending, dat_pending_d, hold_last, dat_go;
  logic [7:0]    cur_data;
  logic [7:0]    cur_addr;
  logic          cache_valid;
  logic [7:0]    cache_idx;

  logic [1:0]    mode_d;
  logic [7:0]    data_d;
  logic          write_d, busy_d, ready_d;

  assign empty     = (count == '0);
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr];
  assign {head_vram, head_addr, head_data} = head;
  assign head_hit  = !head_vram && cache_valid && (cache_idx == head_addr);
  assign hold_last = (state == HOLD) && (cnt == CW'(HOLD_CYCLES - 1));
  assign dat_go    = hold_last && dat_pending;
  // A pending data phase always wins over the next queued command
  assign pop       = !empty && ((state == IDLE) || (hold_last && !dat_pending));
  assign count_d   = count + (AW+1)'(push) - (AW+1)'(pop);
  assign vdp_read  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!empty) state_d = SETUP;
      SETUP:   if (cnt == CW'(SETUP_CYCLES - 1)) state_d = STROBE;
      STROBE:  if (cnt == CW'(STROBE_CYCLES - 1)) state_d = HOLD;
      HOLD:    if (hold_last) state_d = (dat_pending || !empty) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d        = vdp_mode;
    data_d        = vdp_data;
    phase_d       = phase;
    dat_pending_d = dat_pending;
    if (pop) begin
      if (head_vram) begin
        phase_d       = PH_VRM;
        mode_d        = 2'd2;
        data_d        = head_data;
        dat_pending_d = 1'b0;
      end else if (head_hit) begin
        phase_d       = PH_DAT;
        mode_d        = 2'd1;
        data_d        = head_data;
        dat_pending_d = 1'b0;
      end else begin
        phase_d       = PH_SEL;
        mode_d        = 2'd0;
        data_d        = head_addr;
        dat_pending_d = 1'b1;
      end
    end else if (dat_go) begin
      phase_d       = PH_DAT;
      mode_d        = 2'd1;
      data_d        = cur_data;
      dat_pending_d = 1'b0;
    end
    write_d = (state_d == STROBE);
    busy_d  = (state_d != IDLE) || (count_d != '0);
    ready_d = (count_d != (AW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_vram, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cnt         <= '0;
      phase       <= PH_SEL;
      dat_pending <= 1'b0;
      cur_addr    <= '0;
      cur_data    <= '0;
      cache_valid <= 1'b0;
      cache_idx   <= '0;
      vdp_mode    <= '0;
      vdp_write   <= 1'b0;
      vdp_data    <= '0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        cur_addr <= head_addr;
        cur_data <= head_data;
      end
      count       <= count_d;
      cnt         <= (state_d != state) ? '0 : cnt + CW'(1);
      phase       <= phase_d;
      dat_pending <= dat_pending_d;
      if (hold_last && (phase == PH_SEL)) begin
        cache_valid <= 1'b1;
        cache_idx   <= cur_addr;
      end
      vdp_mode  <= mode_d;
      vdp_write <= write_d;
      vdp_data  <= data_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_vdp_reg_writer.sv
// tb/tb_vdp_reg_writer.sv - directed self-checking bench for vdp_reg_writer
module tb_vdp_reg_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_vram = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_data = '0;
  logic       cmd_ready, busy, vdp_write, vdp_read;
  logic [1:0] vdp_mode;
  logic [7:0] vdp_data;

  logic       cmd_valid2 = 1'b0, cmd_vram2 = 1'b0;
  logic [7:0] cmd_addr2 = '0, cmd_data2 = '0;
  logic       cmd_ready2, busy2, vdp_write2, vdp_read2;
  logic [1:0] vdp_mode2;
  logic [7:0] vdp_data2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vdp_reg_writer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vram(cmd_vram), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy),
    .vdp_mode(vdp_mode), .vdp_write(vdp_write), .vdp_read(vdp_read), .vdp_data(vdp_data)
  );

  vdp_reg_writer #(.FIFO_DEPTH(4), .SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_vram(cmd_vram2), .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .busy(busy2),
    .vdp_mode(vdp_mode2), .vdp_write(vdp_write2), .vdp_read(vdp_read2), .vdp_data(vdp_data2)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] len;
  } strobe_t;

  strobe_t    strobes[$];
  logic       prev_w = 1'b0;
  logic [7:0] run = '0;

  // Records each completed strobe with its mode, data and high time
  always @(negedge clk) begin
    if (vdp_write) run <= prev_w ? run + 8'd1 : 8'd1;
    else if (prev_w) strobes.push_back(strobe_t'({vdp_mode, vdp_data, run}));
    prev_w <= vdp_write;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    strobes.delete();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (vdp_mode !== 2'd0) begin failures++; $display("FAIL reset_mode got %0d want 0", vdp_mode); end
    checks++; if (vdp_write !== 1'b0) begin failures++; $display("FAIL reset_write got %b want 0", vdp_write); end
    checks++; if (vdp_read !== 1'b0) begin failures++; $display("FAIL reset_read got %b want 0", vdp_read); end
    checks++; if (vdp_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", vdp_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (busy2 !== 1'b0 || cmd_ready2 !== 1'b1) begin
      failures++; $display("FAIL reset_dut2 got busy=%b ready=%b want busy=0 ready=1", busy2, cmd_ready2);
    end
  endtask

  task automatic test_uncached_write;
    logic [11:0] exp_t [10];
    logic [11:0] got;
    // {mode, data, write, busy} sampled after E, E+1 .. E+9
    exp_t = '{{2'd0, 8'h00, 1'b0, 1'b1}, {2'd0, 8'h05, 1'b0, 1'b1}, {2'd0, 8'h05, 1'b1, 1'b1},
              {2'd0, 8'h05, 1'b1, 1'b1}, {2'd0, 8'h05, 1'b0, 1'b1}, {2'd1, 8'h83, 1'b0, 1'b1},
              {2'd1, 8'h83, 1'b1, 1'b1}, {2'd1, 8'h83, 1'b1, 1'b1}, {2'd1, 8'h83, 1'b0, 1'b1},
              {2'd1, 8'h83, 1'b0, 1'b0}};
    cmd_vram = 1'b0; cmd_addr = 8'h05; cmd_data = 8'h83; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick;
      got = {vdp_mode, vdp_data, vdp_write, busy};
      checks++;
      if (got !== exp_t[i]) begin
        failures++;
        $display("FAIL uncached_cycle%0d got mode/data/write/busy=%h want %h", i, got, exp_t[i]);
      end
    end
  endtask

  task automatic test_cache_hit;
    strobe_t exp_s [3];
    strobe_t got;
    int n;
    apply_reset();
    exp_s = '{{2'd0, 8'h05, 8'd2}, {2'd1, 8'h10, 8'd2}, {2'd1, 8'h20, 8'd2}};
    cmd_vram = 1'b0; cmd_addr = 8'h05; cmd_data = 8'h10; cmd_valid = 1'b1;
    tick;
    cmd_data = 8'h20;
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin tick; n++; end
    checks++; if (n != 12) begin failures++; $display("FAIL cache_duration got %0d cycles want 12", n); end
    checks++; if (strobes.size() != 3) begin failures++; $display("FAIL cache_strobe_count got %0d want 3", strobes.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < strobes.size()) ? strobes[i] : '0;
      checks++;
      if (got !== exp_s[i]) begin failures++; $display("FAIL cache_strobe%0d got %h want %h", i, got, exp_s[i]); end
    end
  endtask

  task automatic test_vram_between;
    strobe_t exp_s [4];
    strobe_t got;
    int n;
    apply_reset();
    exp_s = '{{2'd0, 8'h07, 8'd2}, {2'd1, 8'h01, 8'd2}, {2'd2, 8'hAA, 8'd2}, {2'd1, 8'h02, 8'd2}};
    cmd_vram = 1'b0; cmd_addr = 8'h07; cmd_data = 8'h01; cmd_valid = 1'b1;
    tick;
    cmd_vram = 1'b1; cmd_addr = 8'h33; cmd_data = 8'hAA;
    tick;
    cmd_vram = 1'b0; cmd_addr = 8'h07; cmd_data = 8'h02;
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin tick; n++; end
    checks++; if (n != 15) begin failures++; $display("FAIL vram_duration got %0d cycles want 15", n); end
    checks++; if (strobes.size() != 4) begin failures++; $display("FAIL vram_strobe_count got %0d want 4", strobes.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < strobes.size()) ? strobes[i] : '0;
      checks++;
      if (got !== exp_s[i]) begin failures++; $display("FAIL vram_strobe%0d got %h want %h", i, got, exp_s[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [6];
    logic       exp_ready [10];
    int         idx, first_idle;
    logic       rdy_before, v;
    strobe_t    got;
    apply_reset();
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    // The first command pops while the rest arrive, so the FIFO fills on the fifth push
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    idx = 0;
    first_idle = -1;
    for (int k = 0; k < 60 && first_idle < 0; k++) begin
      if (idx < 6) begin
        cmd_valid = 1'b1; cmd_vram = 1'b1; cmd_addr = 8'hF0; cmd_data = vals[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      rdy_before = cmd_ready;
      v = cmd_valid;
      tick;
      if (v && rdy_before) idx++;
      if (k < 10) begin
        checks++;
        if (cmd_ready !== exp_ready[k]) begin
          failures++; $display("FAIL b2b_ready_cycle%0d got %b want %b", k, cmd_ready, exp_ready[k]);
        end
      end
      if (busy !== 1'b1) first_idle = k;
    end
    cmd_valid = 1'b0;
    checks++; if (idx != 6) begin failures++; $display("FAIL b2b_accepted got %0d want 6", idx); end
    checks++; if (first_idle != 25) begin failures++; $display("FAIL b2b_first_idle got %0d want 25", first_idle); end
    checks++; if (strobes.size() != 6) begin failures++; $display("FAIL b2b_strobe_count got %0d want 6", strobes.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < strobes.size()) ? strobes[i] : '0;
      checks++;
      if (got !== strobe_t'({2'd2, vals[i], 8'd2})) begin
        failures++; $display("FAIL b2b_strobe%0d got %h want mode=2 data=%h len=2", i, got, vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid_strobe;
    strobe_t exp_s [2];
    strobe_t got;
    int n;
    apply_reset();
    exp_s = '{{2'd0, 8'h12, 8'd2}, {2'd1, 8'h66, 8'd2}};
    cmd_vram = 1'b0; cmd_addr = 8'h12; cmd_data = 8'h55; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    checks++; if ({vdp_mode, vdp_data, vdp_write} !== {2'd0, 8'h12, 1'b0}) begin
      failures++; $display("FAIL abort_setup got mode=%0d data=%h write=%b want 0/12/0", vdp_mode, vdp_data, vdp_write);
    end
    tick;
    checks++; if (vdp_write !== 1'b1) begin failures++; $display("FAIL abort_strobe got write=%b want 1", vdp_write); end
    reset = 1'b1;
    tick;
    checks++; if ({vdp_mode, vdp_data, vdp_write, busy, cmd_ready} !== {2'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_reset got mode=%0d data=%h write=%b busy=%b ready=%b want 0/00/0/0/1",
               vdp_mode, vdp_data, vdp_write, busy, cmd_ready);
    end
    reset = 1'b0;
    tick;
    strobes.delete();
    cmd_vram = 1'b0; cmd_addr = 8'h12; cmd_data = 8'h66; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin tick; n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b want 0", busy); end
    checks++; if (strobes.size() != 2) begin failures++; $display("FAIL abort_strobe_count got %0d want 2", strobes.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < strobes.size()) ? strobes[i] : '0;
      checks++;
      if (got !== exp_s[i]) begin failures++; $display("FAIL abort_strobe%0d got %h want %h", i, got, exp_s[i]); end
    end
  endtask

  task automatic test_custom_timing;
    logic [11:0] exp_t [8];
    logic [11:0] got;
    // dut2: SETUP=2 STROBE=1 HOLD=3; {mode, data, write, busy} after E .. E+7
    exp_t = '{{2'd0, 8'h00, 1'b0, 1'b1}, {2'd2, 8'h3C, 1'b0, 1'b1}, {2'd2, 8'h3C, 1'b0, 1'b1},
              {2'd2, 8'h3C, 1'b1, 1'b1}, {2'd2, 8'h3C, 1'b0, 1'b1}, {2'd2, 8'h3C, 1'b0, 1'b1},
              {2'd2, 8'h3C, 1'b0, 1'b1}, {2'd2, 8'h3C, 1'b0, 1'b0}};
    cmd_vram2 = 1'b1; cmd_addr2 = 8'h01; cmd_data2 = 8'h3C; cmd_valid2 = 1'b1;
    tick;
    cmd_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick;
      got = {vdp_mode2, vdp_data2, vdp_write2, busy2};
      checks++;
      if (got !== exp_t[i]) begin
        failures++;
        $display("FAIL timing_cycle%0d got mode/data/write/busy=%h want %h", i, got, exp_t[i]);
      end
    end
    checks++; if (vdp_read2 !== 1'b0) begin failures++; $display("FAIL timing_read got %b want 0", vdp_read2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_uncached_write();
    test_cache_hit();
    test_vram_between();
    test_back_to_back();
    test_reset_mid_strobe();
    test_custom_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
